// File: rtl/icache_axi_refill.sv
// Line-refill engine for the icache miss path: one AXI4 INCR read burst per
// request, beats packed into a single cache line returned with a one-cycle strobe.
module icache_axi_refill #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 32,
  parameter int BEATS  = 8,
  parameter int AXI_ID = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    refill_req,
  input  logic [ADDR_W-1:0]       refill_addr,
  output logic                    refill_busy,
  output logic                    refill_ret_en,
  output logic [BEATS*BEAT_W-1:0] refill_ret_data,
  output logic                    refill_ret_err,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_W-1:0]       araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [3:0]              arid,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [BEAT_W-1:0]       rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic [3:0]              rid
);

  localparam int LINE_W = BEATS * BEAT_W;
  localparam int OFF_W  = $clog2(BEATS * BEAT_W / 8);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_AR   = 4'b0010,
    S_R    = 4'b0100,
    S_DONE = 4'b1000
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                ret_en_q, ret_en_d;
  logic                busy_q, busy_d;
  logic                ret_err_q, ret_err_d;
  logic                last_slot_s;
  logic                unused_in_s;

  // rid is never checked (single outstanding burst) and the line offset bits are discarded
  assign unused_in_s = ^{rid, refill_addr[OFF_W-1:0]};

  assign last_slot_s = (cnt_q == CNT_W'(BEATS - 1));

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    line_d    = line_q;
    ret_err_d = ret_err_q;
    case (state_q)
      S_IDLE: begin
        if (refill_req) begin
          state_d   = S_AR;
          addr_d    = {refill_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          cnt_d     = '0;
          err_d     = 1'b0;
          line_d    = '0;
          ret_err_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR: begin
        if (arvalid_q && arready) begin
          state_d = S_R;
        end else begin
          state_d = S_AR;
        end
      end
      S_R: begin
        if (rvalid && rready_q) begin
          for (int k = 0; k < BEATS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              line_d[k*BEAT_W +: BEAT_W] = rdata;
            end else begin
              line_d[k*BEAT_W +: BEAT_W] = line_q[k*BEAT_W +: BEAT_W];
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          // rlast and the final slot must coincide; either one alone ends the burst
          err_d = err_q | (rresp != 2'b00) | (rlast != last_slot_s);
          if (rlast || last_slot_s) begin
            state_d   = S_DONE;
            ret_err_d = err_d;
          end else begin
            state_d = S_R;
          end
        end else begin
          state_d = S_R;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    arvalid_d = (state_d == S_AR);
    rready_d  = (state_d == S_R);
    ret_en_d  = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      line_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ret_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      ret_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      line_q    <= line_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ret_en_q  <= ret_en_d;
      busy_q    <= busy_d;
      ret_err_q <= ret_err_d;
    end
  end

  assign refill_busy     = busy_q;
  assign refill_ret_en   = ret_en_q;
  assign refill_ret_data = line_q;
  assign refill_ret_err  = ret_err_q;
  assign arvalid         = arvalid_q;
  assign araddr          = addr_q;
  assign arlen           = 8'(BEATS - 1);
  assign arsize          = 3'($clog2(BEAT_W / 8));
  assign arburst         = 2'b01;
  assign arid            = 4'(AXI_ID);
  assign rready          = rready_q;

endmodule
